// File: rtl/ula_seq_param.sv
// ula_seq_param: WIDTH-bit registered ALU with a start/done handshake.
// Add, sub, logic ops and divide-by-zero finish in one cycle. Multiply
// (shift-add) and divide (restoring) iterate one bit per cycle for WIDTH cycles.
// Every result and flag is held in a register until the next done pulse.
module ula_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Resto,
    output logic             Cout,
    output logic             OV,
    output logic             ERRO,
    output logic             Zero,
    output logic             R_exists,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_SOMA = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MULT = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Iteration registers. {hi_reg, lo_reg} is the shared shift register:
    // multiply keeps partial product in hi and the multiplier in lo;
    // divide keeps the partial remainder in hi and dividend/quotient in lo.
    logic [CNT_W-1:0] cnt_reg;
    logic             is_mul_reg;
    logic [WIDTH-1:0] opnd_reg;     // multiplicand (mult) or divisor (div)
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;

    // Result registers.
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] resto_reg;
    logic             cout_reg;
    logic             ov_reg;
    logic             erro_reg;
    logic             zero_reg;
    logic             rex_reg;

    // Control and result selection.
    logic             load_calc;
    logic             write_res;
    logic [WIDTH-1:0] res_s;
    logic [WIDTH-1:0] res_r;
    logic             res_cout;
    logic             res_ov;
    logic             res_err;

    // Single-cycle datapath.
    logic [WIDTH:0]   soma_sum;
    logic [WIDTH-1:0] sub_diff;
    logic [WIDTH-1:0] and_v, or_v, xor_v, not_v;

    // Iterative datapath.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] hi_iter;
    logic [WIDTH-1:0] lo_iter;

    // Bitwise logic unit, one cell per bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign and_v[gi] = A[gi] & B[gi];
            assign or_v[gi]  = A[gi] | B[gi];
            assign xor_v[gi] = A[gi] ^ B[gi];
            assign not_v[gi] = ~A[gi];
        end
    endgenerate

    assign soma_sum = {1'b0, A} + {1'b0, B};
    assign sub_diff = A - B;

    // One multiply or divide step on the shared shift register.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        // When div_ge holds the true difference is below the divisor, so the
        // low WIDTH bits of the subtraction are exact.
        div_diff  = div_shift[WIDTH-1:0] - opnd_reg;
        if (is_mul_reg) begin
            hi_iter = mul_sum[WIDTH:1];
            lo_iter = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end else begin
            hi_iter = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_iter = {lo_reg[WIDTH-2:0], div_ge};
        end
    end

    // Next-state logic and selection of the value written on done.
    always_comb begin
        state_next = state_reg;
        load_calc  = 1'b0;
        write_res  = 1'b0;
        res_s      = '0;
        res_r      = '0;
        res_cout   = 1'b0;
        res_ov     = 1'b0;
        res_err    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (Op == OP_MULT || (Op == OP_DIV && B != '0)) begin
                        state_next = ST_CALC;
                        load_calc  = 1'b1;
                    end else begin
                        state_next = ST_DONE;
                        write_res  = 1'b1;
                        case (Op)
                            OP_SOMA: begin
                                res_s    = soma_sum[WIDTH-1:0];
                                res_cout = soma_sum[WIDTH];
                                res_ov   = (A[WIDTH-1] == B[WIDTH-1]) &&
                                           (soma_sum[WIDTH-1] != A[WIDTH-1]);
                            end
                            OP_SUB: begin
                                if (A < B) res_err = 1'b1;
                                else       res_s   = sub_diff;
                            end
                            OP_DIV:  res_err = 1'b1;   // only reached with B == 0
                            OP_AND:  res_s   = and_v;
                            OP_OR:   res_s   = or_v;
                            OP_XOR:  res_s   = xor_v;
                            OP_NOT:  res_s   = not_v;
                            default: res_s   = '0;
                        endcase
                    end
                end
            end
            ST_CALC: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                    write_res  = 1'b1;
                    res_s      = lo_iter;
                    if (is_mul_reg) res_ov = |hi_iter;
                    else            res_r  = hi_iter;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Operand latch and iteration registers for multiply/divide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            is_mul_reg <= 1'b0;
            opnd_reg   <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else if (load_calc) begin
            cnt_reg    <= CNT_W'(WIDTH);
            is_mul_reg <= (Op == OP_MULT);
            opnd_reg   <= (Op == OP_MULT) ? A : B;
            hi_reg     <= '0;
            lo_reg     <= (Op == OP_MULT) ? B : A;
        end else if (state_reg == ST_CALC) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            hi_reg  <= hi_iter;
            lo_reg  <= lo_iter;
        end
    end

    // Result and flag registers; they change only when a result is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg     <= '0;
            resto_reg <= '0;
            cout_reg  <= 1'b0;
            ov_reg    <= 1'b0;
            erro_reg  <= 1'b0;
            zero_reg  <= 1'b0;
            rex_reg   <= 1'b0;
        end else if (write_res) begin
            s_reg     <= res_s;
            resto_reg <= res_r;
            cout_reg  <= res_cout;
            ov_reg    <= res_ov;
            erro_reg  <= res_err;
            zero_reg  <= (res_s == '0) && !res_err;
            rex_reg   <= (res_r != '0);
        end
    end

    assign S        = s_reg;
    assign Resto    = resto_reg;
    assign Cout     = cout_reg;
    assign OV       = ov_reg;
    assign ERRO     = erro_reg;
    assign Zero     = zero_reg;
    assign R_exists = rex_reg;
    assign busy     = (state_reg == ST_CALC);
    assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_ula_seq_param.sv
// Testbench for ula_seq_param: an 8-bit and a 16-bit instance driven with
// directed and random operations, compared against an arithmetic model.
module tb_ula_seq_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start8, start16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic [2:0]  op8, op16;

    logic [7:0]  s8, r8;
    logic [15:0] s16, r16;
    logic        cout8, ov8, erro8, zero8, rex8, busy8, done8;
    logic        cout16, ov16, erro16, zero16, rex16, busy16, done16;

    ula_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Op(op8),
        .S(s8), .Resto(r8), .Cout(cout8), .OV(ov8), .ERRO(erro8), .Zero(zero8),
        .R_exists(rex8), .busy(busy8), .done(done8)
    );

    ula_seq_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .A(a16), .B(b16), .Op(op16),
        .S(s16), .Resto(r16), .Cout(cout16), .OV(ov16), .ERRO(erro16), .Zero(zero16),
        .R_exists(rex16), .busy(busy16), .done(done16)
    );

    // Observation mux onto whichever instance is under test.
    bit          sel16 = 1'b0;
    logic [15:0] cur_s, cur_r;
    logic        cur_cout, cur_ov, cur_erro, cur_zero, cur_rex, cur_busy, cur_done;
    assign cur_s    = sel16 ? s16 : {8'd0, s8};
    assign cur_r    = sel16 ? r16 : {8'd0, r8};
    assign cur_cout = sel16 ? cout16 : cout8;
    assign cur_ov   = sel16 ? ov16 : ov8;
    assign cur_erro = sel16 ? erro16 : erro8;
    assign cur_zero = sel16 ? zero16 : zero8;
    assign cur_rex  = sel16 ? rex16 : rex8;
    assign cur_busy = sel16 ? busy16 : busy8;
    assign cur_done = sel16 ? done16 : done8;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        longint unsigned s;
        longint unsigned r;
        bit cout, ov, err, zero, rex;
        int lat;
        int busy_n;
    } res_t;

    // Reference model: plain integer arithmetic on the rules of each op.
    function automatic res_t model(input int w, input longint unsigned a,
                                   input longint unsigned b, input int op);
        res_t x;
        longint unsigned m    = (64'd1 << w) - 1;
        longint unsigned full;
        longint          half = longint'(64'd1 << (w - 1));
        longint          sa, sb, ssum;
        x.s = 0; x.r = 0; x.cout = 0; x.ov = 0; x.err = 0;
        x.lat = 1; x.busy_n = 0;
        case (op)
            0: begin
                full   = a + b;
                x.s    = full & m;
                x.cout = (full > m);
                sa     = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
                sb     = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
                ssum   = sa + sb;
                x.ov   = (ssum >= half) || (ssum < -half);
            end
            1: if (a < b) x.err = 1; else x.s = a - b;
            2: begin
                full = a * b;
                x.s  = full & m;
                x.ov = (full > m);
                x.lat = w + 1; x.busy_n = w;
            end
            3: if (b == 0) x.err = 1;
               else begin
                   x.s = a / b; x.r = a % b;
                   x.lat = w + 1; x.busy_n = w;
               end
            4: x.s = a & b;
            5: x.s = a | b;
            6: x.s = a ^ b;
            default: x.s = (~a) & m;
        endcase
        x.zero = (x.s == 0) && !x.err;
        x.rex  = (x.r != 0);
        return x;
    endfunction

    task automatic drive(input int w, input bit st, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] op);
        if (w == 16) begin
            start16 = st; a16 = a[15:0]; b16 = b[15:0]; op16 = op;
        end else begin
            start8 = st; a8 = a[7:0]; b8 = b[7:0]; op8 = op;
        end
    endtask

    // One transaction: pulse start, scramble inputs afterwards (optionally
    // re-pulsing start while busy), wait for done and compare everything.
    task automatic do_op(input int w, input longint unsigned a, input longint unsigned b,
                         input int op, input bit poke);
        res_t  e;
        int    cyc = 0;
        int    busy_n = 0;
        int    extra_done = 0;
        int    limit = 3 * w + 10;
        string nm;
        e  = model(w, a, b, op);
        nm = $sformatf("w%0d op%0d a=%0d b=%0d", w, op, a, b);
        sel16 = (w == 16);
        @(posedge clk); #1;
        drive(w, 1'b1, a, b, 3'(op));
        @(posedge clk); #1;
        cyc = 1;
        while (!cur_done && cyc < limit) begin
            if (cur_busy) busy_n++;
            drive(w, poke && cur_busy, $urandom, $urandom, 3'($urandom_range(0, 7)));
            @(posedge clk); #1;
            cyc++;
        end
        drive(w, 1'b0, $urandom, $urandom, 3'($urandom_range(0, 7)));
        $display("txn %s -> S=%0d R=%0d Cout=%0d OV=%0d ERRO=%0d Zero=%0d Rex=%0d lat=%0d",
                 nm, cur_s, cur_r, cur_cout, cur_ov, cur_erro, cur_zero, cur_rex, cyc);
        check({nm, " done seen"}, 64'(cur_done), 64'd1);
        check({nm, " latency"},   64'(cyc), 64'(e.lat));
        check({nm, " busy cycles"}, 64'(busy_n), 64'(e.busy_n));
        check({nm, " S"},        64'(cur_s), e.s);
        check({nm, " Resto"},    64'(cur_r), e.r);
        check({nm, " Cout"},     64'(cur_cout), 64'(e.cout));
        check({nm, " OV"},       64'(cur_ov), 64'(e.ov));
        check({nm, " ERRO"},     64'(cur_erro), 64'(e.err));
        check({nm, " Zero"},     64'(cur_zero), 64'(e.zero));
        check({nm, " R_exists"}, 64'(cur_rex), 64'(e.rex));
        repeat (2) begin
            @(posedge clk); #1;
            if (cur_done) extra_done++;
        end
        check({nm, " extra done pulses"}, 64'(extra_done), 64'd0);
        check({nm, " S held"}, 64'(cur_s), e.s);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " S8"},     64'(s8), 64'd0);
        check({tag, " Resto8"}, 64'(r8), 64'd0);
        check({tag, " flags8"}, 64'({cout8, ov8, erro8, zero8, rex8}), 64'd0);
        check({tag, " busy8"},  64'(busy8), 64'd0);
        check({tag, " done8"},  64'(done8), 64'd0);
        check({tag, " S16"},    64'(s16), 64'd0);
        check({tag, " flags16"}, 64'({cout16, ov16, erro16, zero16, rex16, busy16, done16}), 64'd0);
    endtask

    initial begin
        int dn;
        drive(8, 1'b0, 0, 0, 3'd0);
        drive(16, 1'b0, 0, 0, 3'd0);
        #12;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Directed, 8-bit.
        do_op(8, 100, 100, 0, 1'b0);
        do_op(8, 200, 100, 0, 1'b0);
        do_op(8, 5, 7, 1, 1'b0);
        do_op(8, 7, 7, 1, 1'b0);
        do_op(8, 20, 13, 2, 1'b1);
        do_op(8, 15, 17, 2, 1'b0);
        do_op(8, 100, 7, 3, 1'b1);
        do_op(8, 100, 0, 3, 1'b0);
        do_op(8, 8'hF0, 8'h3C, 4, 1'b0);
        do_op(8, 8'hF0, 8'h3C, 5, 1'b0);
        do_op(8, 8'hF0, 8'h3C, 6, 1'b0);
        do_op(8, 8'hF0, 8'h3C, 7, 1'b0);
        do_op(8, 255, 255, 2, 1'b0);
        do_op(8, 255, 1, 3, 1'b0);

        // Directed, 16-bit.
        do_op(16, 300, 300, 2, 1'b1);
        do_op(16, 65535, 1, 0, 1'b0);
        do_op(16, 50000, 7, 3, 1'b0);

        // Reset in the middle of a multiply: leave nonzero outputs first.
        do_op(8, 100, 100, 0, 1'b0);
        sel16 = 1'b0;
        @(posedge clk); #1;
        drive(8, 1'b1, 20, 13, 3'd2);
        @(posedge clk); #1;
        drive(8, 1'b0, 0, 0, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort busy before reset", 64'(busy8), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        dn = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done8) dn++;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) dn++;
        end
        check("aborted op activity", 64'(dn), 64'd0);
        do_op(8, 3, 4, 0, 1'b0);

        // Random operations on both widths.
        for (int i = 0; i < 40; i++) begin
            int w;
            int op;
            longint unsigned m, a, b;
            w  = (i % 2 == 1) ? 16 : 8;
            m  = (64'd1 << w) - 1;
            op = $urandom_range(0, 7);
            a  = longint'($urandom) & m;
            case ($urandom_range(0, 5))
                0:       b = 0;
                1:       b = $urandom_range(1, 15);
                2:       b = a;
                default: b = longint'($urandom) & m;
            endcase
            do_op(w, a, b, op, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ula_seq_param.md
Name: ula_seq_param

Overview:
Parametrised, registered successor of the 8-bit combinational ULA. It is a WIDTH-bit sequential ALU with a start/done handshake. Add, sub and logic ops complete in one cycle. Multiply (shift-add) and divide (restoring) are iterative and take WIDTH cycles. All results and flags are registered. The block sits between the operand registers and the display/flag logic and replaces the combinational ULA plus its external multiplier.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  operand A (unsigned)
B  input  WIDTH  operand B (unsigned)
Op  input  3  000 soma, 001 sub, 010 mult, 011 div, 100 AND, 101 OR, 110 XOR, 111 NOT(A)
S  output  WIDTH  registered result
Resto  output  WIDTH  division remainder (0 for other ops)
Cout  output  1  carry out of soma
OV  output  1  overflow (soma signed, mult)
ERRO  output  1  sub borrow or div by zero
Zero  output  1  S==0 and ERRO==0
R_exists  output  1  Resto!=0 (div only)
busy  output  1  high while in CALC
done  output  1  one-cycle pulse: outputs just updated

Behaviour:
- Reset (async, rst_n=0): state=IDLE; S, Resto, Cout, OV, ERRO, Zero, R_exists, busy, done all 0; counter and internal registers cleared. Reset mid-CALC aborts the operation with no done pulse.
- FSM states: IDLE, CALC, DONE.
- IDLE to DONE: start=1 with Op in {soma, sub, AND, OR, XOR, NOT}, or Op=div with B=0. Result is written at that edge, so latency is 1.
- IDLE to CALC: start=1 with Op=mult, or Op=div with B!=0. A, B and Op are latched; the counter loads WIDTH.
- CALC: one iteration per cycle; counter decrements. At counter=1 the result is written and the FSM goes to DONE. done is asserted in cycle start+WIDTH+1.
- DONE: done=1 for exactly one cycle, then IDLE. start in CALC or DONE is ignored, not queued. Back-to-back ops therefore need start in IDLE.
- Operand changes on A/B/Op after acceptance have no effect.
- Outputs hold their value until the next done; they are never cleared by returning to IDLE.
- soma: S=(A+B) mod 2^WIDTH. Cout = carry out. OV = signed overflow (A[msb]==B[msb] and S[msb]!=A[msb]).
- sub: if A<B then ERRO=1, S=0. Otherwise S=A-B, ERRO=0. Cout=OV=0.
- mult: full 2*WIDTH product. S = low WIDTH bits. OV=1 iff the high half is nonzero. Cout=0.
- div: S=quotient, Resto=remainder, R_exists=(Resto!=0). If B=0 then ERRO=1 and S=Resto=0.
- Logic ops: bitwise; NOT ignores B. Cout=OV=ERRO=0.
- Flags not listed for an op are written 0 at done.
- ERRO=1 forces S=0, Zero=0, Cout=0, OV=0.
- Zero is computed from the final S and is written with S.
- busy=1 exactly while state==CALC.

Test Plan:
- WIDTH=8, soma A=100 B=100, start pulse -> done one cycle later; S=200, Cout=0, OV=1, Zero=0. Then A=200 B=100 -> S=44, Cout=1, OV=0.
- sub A=5 B=7 -> ERRO=1, S=0, Zero=0 after 1 cycle. Then A=7 B=7 -> S=0, Zero=1, ERRO=0.
- mult A=20 B=13 -> busy high for 8 cycles; done in cycle 9 after start; S=4, OV=1. Then A=15 B=17 -> S=255, OV=0. Start pulses during CALC are ignored (done count stays 1).
- div A=100 B=7 -> done in cycle 9; S=14, Resto=2, R_exists=1. Then A=100 B=0 -> done after 1 cycle; ERRO=1, S=0, Resto=0, busy never high.
- Assert rst_n=0 at cycle 4 of a mult -> all outputs 0 immediately (asynchronous), no done pulse; after release, state=IDLE and a new soma completes normally.
- Rerun soma/mult/div checks with WIDTH=16 (e.g. 300*300 -> S=24464, OV=1; done in cycle 17) against a reference model over random operands.
